// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: access types, FSM encoding,
// owner encoding and address-decode helpers.
package mem_arbiter_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } arb_state_t;

    typedef enum logic {
        OWN_LS,
        OWN_IC
    } owner_t;

    // The two address bits just below the IO decode point are both set for IO.
    function automatic logic is_io_region(input logic [1:0] region_bits);
        return region_bits == 2'b11;
    endfunction

    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the icache, load/store buffer and byte-wide memory bus signals
// seen by the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ic_req_in;
    logic [ADDR_WIDTH-1:0] ic_addr_in;
    logic [31:0]           ic_data_out;
    logic                  ic_done_out;

    logic                  ls_req_in;
    logic                  ls_wr_in;
    logic [2:0]            ls_type_in;
    logic [ADDR_WIDTH-1:0] ls_addr_in;
    logic [31:0]           ls_wdata_in;
    logic [31:0]           ls_rdata_out;
    logic                  ls_done_out;

    logic [7:0]            mem_din_in;
    logic [7:0]            mem_dout_out;
    logic [ADDR_WIDTH-1:0] mem_a_out;
    logic                  mem_wr_out;
    logic                  io_buffer_full_in;

    modport slave (
        input  ic_req_in, ic_addr_in, ls_req_in, ls_wr_in, ls_type_in,
               ls_addr_in, ls_wdata_in, mem_din_in, io_buffer_full_in,
        output ic_data_out, ic_done_out, ls_rdata_out, ls_done_out,
               mem_dout_out, mem_a_out, mem_wr_out
    );

    modport master (
        output ic_req_in, ic_addr_in, ls_req_in, ls_wr_in, ls_type_in,
               ls_addr_in, ls_wdata_in, mem_din_in, io_buffer_full_in,
        input  ic_data_out, ic_done_out, ls_rdata_out, ls_done_out,
               mem_dout_out, mem_a_out, mem_wr_out
    );
endinterface

// File: rtl/mem_byte_assembler.sv
// Collects read bytes into a little-endian word and produces the
// sign/zero-extended load result for the latched access type.
module mem_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        clear,
    input  logic        capture,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    input  logic [2:0]  ls_type,
    output logic [31:0] word,
    output logic [31:0] ext
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] byte_reg;

            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    byte_reg <= '0;
                end else if (clear) begin
                    byte_reg <= '0;
                end else if (capture && lane == 2'(gi)) begin
                    byte_reg <= din;
                end
            end

            assign word[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    always_comb begin
        ext = word;
        case (ls_type)
            LS_B:    ext = {{24{word[7]}}, word[7:0]};
            LS_H:    ext = {{16{word[15]}}, word[15:0]};
            LS_BU:   ext = {24'd0, word[7:0]};
            LS_HU:   ext = {16'd0, word[15:0]};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide memory port between the icache
// and the load/store buffer, sequencing multi-byte accesses one byte per cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int IO_HI_BIT  = 17
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    mem_arbiter_if.slave  bus
);

    arb_state_t            state_reg;
    owner_t                owner_reg;
    logic                  last_ic_reg;
    logic                  is_store_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [2:0]            type_reg;
    logic [2:0]            nbytes_reg;
    logic [2:0]            cnt_reg;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  grant_ic;
    logic                  accept;
    logic                  io_stall;
    logic                  read_active;
    logic                  done_fire;
    logic                  capture;
    logic [31:0]           asm_word;
    logic [31:0]           asm_ext;

    assign cur_addr = addr_reg + ADDR_WIDTH'(cnt_reg);

    // When both requesters wait, the one not served last wins.
    assign grant_ic = bus.ic_req_in && (!bus.ls_req_in || !last_ic_reg);
    assign accept   = rdy_in && state_reg == ST_IDLE && !flush_in &&
                      (bus.ic_req_in || bus.ls_req_in);
    assign io_stall = state_reg == ST_WRITE && bus.io_buffer_full_in &&
                      is_io_region(cur_addr[IO_HI_BIT -: 2]);

    assign read_active = state_reg == ST_READ && cnt_reg < nbytes_reg;
    assign capture     = rdy_in && state_reg == ST_READ && cnt_reg != 3'd0;

    // A flush hides a pending read result but never a committed store.
    assign done_fire = rdy_in && state_reg == ST_DONE && !(flush_in && !is_store_reg);

    assign bus.mem_a_out    = (read_active || state_reg == ST_WRITE) ? cur_addr : '0;
    assign bus.mem_dout_out = (state_reg == ST_WRITE) ?
                              wdata_reg[{cnt_reg[1:0], 3'b000} +: 8] : 8'd0;
    assign bus.mem_wr_out   = rdy_in && state_reg == ST_WRITE && !io_stall;

    assign bus.ic_done_out  = done_fire && owner_reg == OWN_IC;
    assign bus.ls_done_out  = done_fire && owner_reg == OWN_LS;
    assign bus.ic_data_out  = bus.ic_done_out ? asm_word : 32'd0;
    assign bus.ls_rdata_out = bus.ls_done_out ? asm_ext : 32'd0;

    mem_byte_assembler u_assembler (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear    (accept),
        .capture  (capture),
        .lane     (2'(cnt_reg - 3'd1)),
        .din      (bus.mem_din_in),
        .ls_type  (type_reg),
        .word     (asm_word),
        .ext      (asm_ext)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWN_LS;
            last_ic_reg  <= 1'b1;
            is_store_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            type_reg     <= LS_W;
            nbytes_reg   <= 3'd4;
            cnt_reg      <= 3'd0;
        end else if (rdy_in) begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        owner_reg    <= grant_ic ? OWN_IC : OWN_LS;
                        last_ic_reg  <= grant_ic;
                        is_store_reg <= !grant_ic && bus.ls_wr_in;
                        addr_reg     <= grant_ic ? bus.ic_addr_in : bus.ls_addr_in;
                        wdata_reg    <= bus.ls_wdata_in;
                        type_reg     <= grant_ic ? LS_W : bus.ls_type_in;
                        nbytes_reg   <= grant_ic ? 3'd4 : access_bytes(bus.ls_type_in);
                        cnt_reg      <= 3'd0;
                        state_reg    <= (!grant_ic && bus.ls_wr_in) ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (flush_in) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == nbytes_reg) begin
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (!io_stall) begin
                        if (cnt_reg == nbytes_reg - 3'd1) begin
                            state_reg <= ST_DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 3'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
